bpsk_rx_ctrl: RTL and testbench
===============================

Name: bpsk_rx_ctrl

Overview:
Receive-side counterpart of the BPSK transmit controller. Takes the hard-decision carrier phase from the demodulator and recovers bit timing from phase transitions. Differentially decodes the bits (phase toggles for a 1), hunts for a 32-bit sync word, then deserializes a fixed-length frame MSB-first and writes each word into a dual-port frame RAM for the PS to read.

Parameters:
DATA_WIDTH, 32, RAM word width and deserializer length
FRAME_LENGTH, 38, payload words per frame written after sync
ADDR_WIDTH, 6, RAM address width
REF_CLK_FREQ, 128000000, clk frequency in Hz
BAUDRATE, 9600, bit rate; BIT_CYCLES = REF_CLK_FREQ/BAUDRATE (integer, 13333), HALF = BIT_CYCLES/2
SYNC_WORD, 32'h1ACFFC1D, frame marker, compared MSB-first

Ports:
clk  in  1  system clock
nrst  in  1  synchronous, active-low reset
rx_enable  in  1  receiver enable; low forces IDLE
phase_in  in  1  demodulator hard phase decision, asynchronous to clk
ram_clk  out  1  equals clk
ram_en  out  1  high whenever state != IDLE
ram_we  out  1  one-cycle write strobe per received word
ram_addr  out  ADDR_WIDTH  write address
ram_wr_data  out  DATA_WIDTH  received word
ram_rst  out  1  constant 0
sync_lock  out  1  high in RECV
frame_done  out  1  one-cycle pulse with the last word's ram_we
bit_strobe  out  1  one-cycle pulse per decoded bit (debug)

Behaviour:
- Reset: all outputs 0, state IDLE, all counters/shift registers 0, prev_phase 0.
- Input path: phase_in passes through a 2-flop synchronizer, then a registered edge detect (sync != sync_d).
- Baud counter, 0..BIT_CYCLES-1:
  - An edge forces it to 0.
  - Otherwise it increments and wraps from BIT_CYCLES-1 to 0.
  - It free-runs so that long runs of 0-bits with no edge are still sampled.
  - Sample strobe when counter == HALF-1 and state != IDLE.
- Differential decode on the strobe: bit = sync_d XOR prev_phase, then prev_phase <= sync_d. bit_strobe and the decoded bit are registered, one cycle after the strobe.
- State IDLE:
  - Counters, shift register and prev_phase held at 0; no writes.
  - rx_enable=1 moves to HUNT on the next cycle.
- State HUNT:
  - Each bit shifts into shreg = {shreg[30:0], bit}.
  - When the post-shift value == SYNC_WORD: go to RECV, bit_cnt <= 0, word_cnt <= 0, ram_addr <= 0.
- State RECV:
  - Each bit shifts in and bit_cnt increments.
  - On the 32nd bit (bit_cnt == DATA_WIDTH-1), in the next cycle:
    - ram_we=1, ram_wr_data=assembled word, ram_addr=word_cnt.
    - bit_cnt <= 0.
    - ram_addr/word_cnt advance by 1 after the write.
  - When the write is word FRAME_LENGTH-1, frame_done=1 in the same cycle, then ram_addr <= 0 and the state returns to HUNT with shreg cleared.
- rx_enable low in any state: IDLE on the next cycle. A partial word is discarded, no write occurs, and frame_done is not asserted.
- Edge coinciding with the sample point: the edge reset takes priority, so no sample in that cycle.
- An edge during RECV re-phases the counter and never aborts the frame.
- ram_we is never asserted outside RECV.
- ram_addr never exceeds FRAME_LENGTH-1.
- nrst low mid-frame: everything returns to reset values on the next clk.

Decomposition:
- Package bpsk_pkg:
  - state enum {IDLE, HUNT, RECV}
  - localparams BIT_CYCLES and HALF derived from REF_CLK_FREQ/BAUDRATE
  - default SYNC_WORD
- Sub-module bpsk_bit_sync: synchronizer, edge detect, baud counter, differential decode. Outputs bit_valid/bit_data.
- Top level: FSM, deserializer, RAM write port.

Test Plan:
All scenarios run with REF_CLK_FREQ=1600, BAUDRATE=100 (BIT_CYCLES=16, HALF=8) and FRAME_LENGTH=4.
- Reset and idle: nrst low 5 cycles, then rx_enable=0 with phase_in toggling -> all outputs 0, no ram_we.
- Sync and frame: transmit-model stream of SYNC_WORD then 0xDEADBEEF, 0x00000000, 0xFFFFFFFF, 0x12345678 (phase toggles per 1-bit) -> sync_lock rises after the 32nd sync bit; four ram_we at addr 0..3 with those exact words; frame_done coincident with the addr-3 write; sync_lock then falls.
- Long zero run: payload 0x00000000 (no phase edges for 32 bits) -> word 0x00000000 written, with exactly 32 bit_strobes between writes.
- Timing drift: per-bit period alternating 15 and 17 cycles -> all words still decoded correctly.
- False sync: stream containing 0x1ACFFC1C -> no lock, no ram_we.
- Abort: rx_enable dropped after 2 words, then re-enabled with a full frame -> no write for the partial word, no frame_done for the aborted frame; the new frame starts at addr 0 and all 4 words are correct.

Source files
------------

// File: rtl/bpsk_pkg.sv
// Shared types and defaults for the BPSK receive controller.
//   state_t      : receiver FSM states
//   BIT_CYCLES   : default clk cycles per bit (128 MHz / 9600 baud)
//   HALF         : default mid-bit sample offset
//   DEF_SYNC_WORD: default frame marker
package bpsk_pkg;
  typedef enum logic [1:0] {IDLE, HUNT, RECV} state_t;

  localparam int DEF_REF_CLK_FREQ = 128000000;
  localparam int DEF_BAUDRATE     = 9600;
  localparam int BIT_CYCLES       = DEF_REF_CLK_FREQ / DEF_BAUDRATE;
  localparam int HALF             = BIT_CYCLES / 2;
  localparam logic [31:0] DEF_SYNC_WORD = 32'h1ACFFC1D;

  function automatic int bit_cycles(input int ref_clk_freq, input int baudrate);
    return ref_clk_freq / baudrate;
  endfunction
endpackage

// File: rtl/bpsk_rx_ctrl_if.sv
// Frame RAM write port plus receiver status, driven by bpsk_rx_ctrl.
//   ram_clk/ram_en/ram_we/ram_addr/ram_wr_data/ram_rst : RAM port A
//   sync_lock  : receiver is inside a frame
//   frame_done : pulse with the last word's write
//   bit_strobe : pulse per decoded bit
interface bpsk_rx_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  logic                  ram_clk;
  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic                  ram_rst;
  logic                  sync_lock;
  logic                  frame_done;
  logic                  bit_strobe;

  modport master (output ram_clk, ram_en, ram_we, ram_addr, ram_wr_data, ram_rst,
                         sync_lock, frame_done, bit_strobe);
  modport slave  (input  ram_clk, ram_en, ram_we, ram_addr, ram_wr_data, ram_rst,
                         sync_lock, frame_done, bit_strobe);
endinterface

// File: rtl/bpsk_bit_sync.sv
// Bit timing recovery and differential decode.
//   clk, nrst : clock, synchronous active-low reset
//   active    : receiver not idle; low holds counter and phase memory at 0
//   phase_in  : asynchronous hard phase decision
//   bit_valid : one-cycle pulse per decoded bit
//   bit_data  : decoded bit (1 = phase toggled since previous bit)
module bpsk_bit_sync #(
  parameter int BIT_CYCLES = 16,
  parameter int HALF       = 8
) (
  input  logic clk,
  input  logic nrst,
  input  logic active,
  input  logic phase_in,
  output logic bit_valid,
  output logic bit_data
);
  localparam int CW = $clog2(BIT_CYCLES);

  logic          s1, s2, s_d, prev_phase;
  logic [CW-1:0] cnt;
  logic          edge_det, strobe;

  assign edge_det = s2 ^ s_d;
  // an edge re-phases the counter, so it suppresses a coincident sample
  assign strobe   = active && !edge_det && (cnt == CW'(HALF-1));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      s1 <= 1'b0; s2 <= 1'b0; s_d <= 1'b0;
      cnt <= '0; prev_phase <= 1'b0;
      bit_valid <= 1'b0; bit_data <= 1'b0;
    end else begin
      s1  <= phase_in;
      s2  <= s1;
      s_d <= s2;
      if (!active) begin
        cnt        <= '0;
        prev_phase <= 1'b0;
      end else begin
        // free-running so runs of 0-bits without edges keep being sampled
        if (edge_det || cnt == CW'(BIT_CYCLES-1)) cnt <= '0;
        else                                      cnt <= cnt + CW'(1);
        if (strobe) prev_phase <= s_d;
      end
      bit_valid <= strobe;
      bit_data  <= strobe ? (s_d ^ prev_phase) : 1'b0;
    end
  end
endmodule

// File: rtl/bpsk_rx_ctrl.sv
// BPSK receive controller: hunts for the sync word in the decoded bit
// stream, then deserializes FRAME_LENGTH words MSB-first into frame RAM.
//   clk, nrst : clock, synchronous active-low reset
//   rx_enable : receiver enable; low returns to IDLE and drops a partial frame
//   phase_in  : asynchronous demodulator phase decision
//   ram       : frame RAM write port and status (master side)
module bpsk_rx_ctrl
  import bpsk_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    FRAME_LENGTH = 38,
  parameter int                    ADDR_WIDTH   = 6,
  parameter int                    REF_CLK_FREQ = 128000000,
  parameter int                    BAUDRATE     = 9600,
  parameter logic [DATA_WIDTH-1:0] SYNC_WORD    = DEF_SYNC_WORD
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            rx_enable,
  input  logic            phase_in,
  bpsk_rx_ctrl_if.master  ram
);
  localparam int BC = bit_cycles(REF_CLK_FREQ, BAUDRATE);
  localparam int BW = $clog2(DATA_WIDTH);

  state_t                state, state_nx;
  logic                  bit_valid, bit_data;
  logic [DATA_WIDTH-1:0] shreg, shift_val, wr_data;
  logic [BW-1:0]         bit_cnt;
  logic [ADDR_WIDTH-1:0] word_cnt;
  logic                  we, done, last_word;

  bpsk_bit_sync #(.BIT_CYCLES(BC), .HALF(BC/2)) u_bit_sync (
    .clk(clk), .nrst(nrst), .active(state != IDLE), .phase_in(phase_in),
    .bit_valid(bit_valid), .bit_data(bit_data)
  );

  assign shift_val = {shreg[DATA_WIDTH-2:0], bit_data};
  assign last_word = (word_cnt == ADDR_WIDTH'(FRAME_LENGTH-1));

  always_ff @(posedge clk) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!rx_enable) state_nx = IDLE;
    else begin
      case (state)
        IDLE:    state_nx = HUNT;
        HUNT:    if (bit_valid && shift_val == SYNC_WORD) state_nx = RECV;
        RECV:    if (we && last_word) state_nx = HUNT;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst || !rx_enable || state == IDLE) begin
      shreg <= '0; bit_cnt <= '0; word_cnt <= '0;
      we <= 1'b0; done <= 1'b0; wr_data <= '0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      if (state == HUNT && bit_valid) begin
        shreg <= shift_val;
        if (shift_val == SYNC_WORD) begin
          bit_cnt  <= '0;
          word_cnt <= '0;
        end
      end
      if (state == RECV) begin
        if (bit_valid) begin
          shreg <= shift_val;
          if (bit_cnt == BW'(DATA_WIDTH-1)) begin
            bit_cnt <= '0;
            we      <= 1'b1;
            wr_data <= shift_val;
            done    <= last_word;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        // address advances after the write cycle; last word wraps back to hunting
        if (we) begin
          if (last_word) begin
            word_cnt <= '0;
            shreg    <= '0;
          end else begin
            word_cnt <= word_cnt + ADDR_WIDTH'(1);
          end
        end
      end
    end
  end

  assign ram.ram_clk     = clk;
  assign ram.ram_en      = (state != IDLE);
  assign ram.ram_we      = we;
  assign ram.ram_addr    = word_cnt;
  assign ram.ram_wr_data = wr_data;
  assign ram.ram_rst     = 1'b0;
  assign ram.sync_lock   = (state == RECV);
  assign ram.frame_done  = done;
  assign ram.bit_strobe  = bit_valid;
endmodule

// File: tb/tb_bpsk_rx_ctrl.sv
// Bench for bpsk_rx_ctrl at 16 clk per bit, 4-word frames.
module tb_bpsk_rx_ctrl;
  import bpsk_pkg::*;

  localparam int FL = 4;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam logic [31:0] SYNC = 32'h1ACFFC1D;

  logic clk = 1'b0, nrst = 1'b0, rx_enable = 1'b0, phase_in = 1'b0;
  always #5 clk = ~clk;

  bpsk_rx_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ram ();

  bpsk_rx_ctrl #(.DATA_WIDTH(DW), .FRAME_LENGTH(FL), .ADDR_WIDTH(AW),
                 .REF_CLK_FREQ(1600), .BAUDRATE(100), .SYNC_WORD(SYNC)) dut (
    .clk(clk), .nrst(nrst), .rx_enable(rx_enable), .phase_in(phase_in), .ram(ram)
  );

  typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data; logic done;} wr_t;
  typedef struct {logic nrst, rx_en, ph; logic [4:0] exp;} vec_t; // exp = {en,we,lock,done,strobe}

  wr_t  got[$], exp_q[$];
  int   gaps[$];
  bit   stream[$];
  logic lock_hist[$];
  int   vectors = 0, errors = 0;
  int   strobes = 0, done_cnt = 0;
  logic lock_seen = 1'b0, en_exp = 1'b0;
  bit   alt = 1'b0;

  // ---------------- per-cycle monitor ----------------
  always @(posedge clk) en_exp <= nrst & rx_enable;

  always @(negedge clk) begin
    vectors++;
    if (ram.ram_en !== en_exp) begin
      errors++; $display("FAIL ram_en t=%0t got %b want %b", $time, ram.ram_en, en_exp);
    end
    if (ram.ram_we === 1'b1 && ram.sync_lock !== 1'b1) begin
      errors++; $display("FAIL we_outside_recv t=%0t got we=1 lock=%b want lock=1", $time, ram.sync_lock);
    end
    if (ram.ram_addr > AW'(FL-1)) begin
      errors++; $display("FAIL addr_range t=%0t got %0d want <= %0d", $time, ram.ram_addr, FL-1);
    end
    if (ram.ram_rst !== 1'b0) begin
      errors++; $display("FAIL ram_rst t=%0t got %b want 0", $time, ram.ram_rst);
    end
    if (ram.frame_done === 1'b1 && ram.ram_we !== 1'b1) begin
      errors++; $display("FAIL done_without_we t=%0t got we=%b want 1", $time, ram.ram_we);
    end
    if (ram.sync_lock === 1'b1) lock_seen = 1'b1;
    if (ram.bit_strobe === 1'b1) strobes++;
    if (ram.frame_done === 1'b1) done_cnt++;
    if (ram.ram_we === 1'b1) begin
      got.push_back('{addr: ram.ram_addr, data: ram.ram_wr_data, done: ram.frame_done});
      gaps.push_back(strobes);
      strobes = 0;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      errors++; $display("FAIL %s got %0h want %0h", name, act, want);
    end
  endtask

  // Transmitter: phase toggles at the start of every 1-bit.
  task automatic send_bit(input bit b, input bit drift);
    int per;
    per = drift ? (alt ? 17 : 15) : 16;
    alt = ~alt;
    stream.push_back(b);
    if (b) phase_in = ~phase_in;
    repeat (per) @(posedge clk);
    #1;
    lock_hist.push_back(ram.sync_lock);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input bit drift);
    for (int i = n-1; i >= 0; i--) send_bit(v[i], drift);
  endtask

  task automatic send_frame(input logic [31:0] w0, w1, w2, w3, input bit drift);
    send_bits(32'hAA, 8, drift);
    send_bits(SYNC, 32, drift);
    send_bits(w0, 32, drift); send_bits(w1, 32, drift);
    send_bits(w2, 32, drift); send_bits(w3, 32, drift);
  endtask

  task automatic start_rx(input bit clr);
    rx_enable = 1'b0; phase_in = 1'b0;
    repeat (6) @(posedge clk); #1;
    rx_enable = 1'b1;
    repeat (4) @(posedge clk); #1;
    stream.delete(); lock_hist.delete();
    strobes = 0; lock_seen = 1'b0;
    if (clr) begin got.delete(); gaps.delete(); exp_q.delete(); done_cnt = 0; end
  endtask

  // Reference: scan the transmitted bit list for the marker, then take the
  // following FRAME_LENGTH 32-bit groups as words; resume hunting from zero.
  task automatic run_model();
    logic [31:0] win, w;
    int i;
    bit trunc;
    win = '0; i = 0; trunc = 0;
    while (i < stream.size() && !trunc) begin
      win = {win[30:0], stream[i]}; i++;
      if (win == SYNC) begin
        for (int k = 0; k < FL; k++) begin
          if (!trunc) begin
            if (i + 32 > stream.size()) trunc = 1;
            else begin
              w = '0;
              for (int b = 0; b < 32; b++) w = {w[30:0], stream[i+b]};
              i += 32;
              exp_q.push_back('{addr: AW'(k), data: w, done: (k == FL-1)});
            end
          end
        end
        win = '0;
      end
    end
  endtask

  task automatic check_writes(input string name);
    chk({name, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_wr%0d", name, i), 64'(got[i]), 64'(exp_q[i]));
  endtask

  // ---------------- test ----------------
  vec_t tbl[14];
  logic [31:0] hand_w[4];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 5'b00000};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 5'b00000};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 5'b00000};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 5'b00000};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 5'b00000};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 5'b00000};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 5'b00000};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 5'b10000};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 5'b10000};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 5'b00000};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 5'b00000};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 5'b00000};

    // reset and idle behaviour, one clock per record
    @(negedge clk); #1;
    for (int i = 0; i < 14; i++) begin
      nrst = tbl[i].nrst; rx_enable = tbl[i].rx_en; phase_in = tbl[i].ph;
      @(posedge clk); @(negedge clk);
      chk($sformatf("tbl%0d", i),
          {ram.ram_en, ram.ram_we, ram.sync_lock, ram.frame_done, ram.bit_strobe}, tbl[i].exp);
      chk($sformatf("tbl%0d_addr_data", i), {ram.ram_addr, ram.ram_wr_data}, '0);
      #1;
    end
    @(posedge clk); #1;
    chk("ram_clk_high", ram.ram_clk, 1'b1);
    @(negedge clk); #1;
    chk("ram_clk_low", ram.ram_clk, 1'b0);

    // sync and frame with known words
    hand_w[0] = 32'hDEADBEEF; hand_w[1] = 32'h0; hand_w[2] = 32'hFFFFFFFF; hand_w[3] = 32'h12345678;
    start_rx(1);
    send_frame(hand_w[0], hand_w[1], hand_w[2], hand_w[3], 0);
    repeat (40) @(posedge clk); #1;
    chk("lock_before_last_sync_bit", lock_hist[38], 1'b0);
    chk("lock_after_last_sync_bit", lock_hist[39], 1'b1);
    chk("frame_wr_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("frame_wr%0d", i), 64'(got[i]), 64'({AW'(i), hand_w[i], i == 3}));
    chk("frame_done_count", done_cnt, 1);
    chk("lock_after_frame", ram.sync_lock, 1'b0);

    // long zero run: no edges inside the payload
    start_rx(1);
    send_frame(32'h0, 32'h0, 32'h0, 32'h0, 0);
    repeat (40) @(posedge clk); #1;
    run_model();
    check_writes("zero");
    for (int i = 1; i < 4 && i < gaps.size(); i++)
      chk($sformatf("zero_gap%0d", i), gaps[i], 32);

    // bit period alternating 15/17
    start_rx(1);
    send_frame($urandom, $urandom, $urandom, $urandom, 1);
    repeat (40) @(posedge clk); #1;
    run_model();
    check_writes("drift");

    // randomized frames with random leading bits
    for (int r = 0; r < 3; r++) begin
      start_rx(1);
      send_bits($urandom, 16, 0);
      send_frame($urandom, $urandom, $urandom, $urandom, 0);
      repeat (40) @(posedge clk); #1;
      run_model();
      check_writes($sformatf("rand%0d", r));
    end

    // marker off by one bit
    start_rx(1);
    send_bits(32'hAA, 8, 0);
    send_bits(32'h1ACFFC1C, 32, 0);
    send_bits(32'h0, 32, 0);
    repeat (40) @(posedge clk); #1;
    chk("false_sync_wr_count", got.size(), 0);
    chk("false_sync_lock", lock_seen, 1'b0);

    // abort after two words plus half a word, then a clean frame
    start_rx(1);
    send_bits(32'hAA, 8, 0);
    send_bits(SYNC, 32, 0);
    send_bits(32'hCAFEF00D, 32, 0);
    send_bits(32'h5A5A0F0F, 32, 0);
    send_bits(32'h0000FFFF, 16, 0);
    rx_enable = 1'b0;
    run_model();
    repeat (40) @(posedge clk); #1;
    chk("abort_wr_count", got.size(), 2);
    chk("abort_done_count", done_cnt, 0);
    start_rx(0);
    send_frame($urandom, $urandom, $urandom, $urandom, 0);
    repeat (40) @(posedge clk); #1;
    run_model();
    check_writes("abort");
    chk("abort_done_after_new", done_cnt, 1);

    // reset in the middle of a frame
    start_rx(1);
    send_bits(32'hAA, 8, 0);
    send_bits(SYNC, 32, 0);
    send_bits(32'hFFFF0000, 20, 0);
    chk("midrst_locked", ram.sync_lock, 1'b1);
    nrst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("midrst_outputs",
        {ram.ram_en, ram.ram_we, ram.sync_lock, ram.frame_done, ram.bit_strobe, ram.ram_addr}, '0);
    #1; nrst = 1'b1;
    repeat (40) @(posedge clk); #1;
    chk("midrst_no_writes", got.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
